// File: rtl/framebuffer_reader_if.sv
// Pixel BRAM read port plus the valid/ready pixel stream carrying data and raster coordinates.
interface framebuffer_reader_if #(
   parameter int ADDR_BITS   = 18,
   parameter int PIXEL_WIDTH = 16
);
   logic [ADDR_BITS-1:0]   bram_addr;
   logic [PIXEL_WIDTH-1:0] bram_dout;
   logic                   pixel_valid;
   logic                   pixel_ready;
   logic [PIXEL_WIDTH-1:0] pixel_data;
   logic [15:0]            pixel_x;
   logic [15:0]            pixel_y;
   logic                   pixel_eol;
   logic                   pixel_last;

   modport master (
      output bram_addr,
      input  bram_dout,
      output pixel_valid,
      input  pixel_ready,
      output pixel_data,
      output pixel_x,
      output pixel_y,
      output pixel_eol,
      output pixel_last
   );

   modport slave (
      input  bram_addr,
      output bram_dout,
      input  pixel_valid,
      output pixel_ready,
      input  pixel_data,
      input  pixel_x,
      input  pixel_y,
      input  pixel_eol,
      input  pixel_last
   );
endinterface

// File: rtl/framebuffer_reader.sv
// Raster-order frame reader: walks the active region of the pixel BRAM and streams pixels
// with coordinates; a credit-limited skid FIFO absorbs BRAM latency under backpressure.
module framebuffer_reader #(
   parameter int FRAME_WIDTH  = 512,
   parameter int FRAME_HEIGHT = 384,
   parameter int ADDR_BITS    = 18,
   parameter int PIXEL_WIDTH  = 16,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [15:0]          width_in,
   input  logic [15:0]          height_in,
   output logic                 busy,
   output logic                 done,
   framebuffer_reader_if.master bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   function automatic logic [15:0] sat_dim(input logic [15:0] v, input int lim);
      return (v > 16'(lim)) ? 16'(lim) : v;
   endfunction

   function automatic logic [ADDR_BITS-1:0] addr_of(input logic [15:0] x, input logic [15:0] y);
      return ADDR_BITS'(FRAME_WIDTH) * ADDR_BITS'(y) + ADDR_BITS'(x);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   logic [1:0]  state;
   logic [15:0] width_q, height_q;
   logic [15:0] rx, ry;
   logic [15:0] width_clamp, height_clamp;
   logic        issue, eol_issue, last_issue;

   logic [READ_LATENCY-1:0] vld_p;
   logic [15:0]             tag_x_p    [READ_LATENCY];
   logic [15:0]             tag_y_p    [READ_LATENCY];
   logic                    tag_eol_p  [READ_LATENCY];
   logic                    tag_last_p [READ_LATENCY];

   logic [PIXEL_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [15:0]            fifo_x    [FIFO_DEPTH];
   logic [15:0]            fifo_y    [FIFO_DEPTH];
   logic                   fifo_eol  [FIFO_DEPTH];
   logic                   fifo_last [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0]       fifo_count;
   logic [CNT_W:0]         inflight, credit_sum;
   logic                   fifo_wr, fifo_rd, head_valid;

   assign width_clamp  = sat_dim(width_in, FRAME_WIDTH);
   assign height_clamp = sat_dim(height_in, FRAME_HEIGHT);

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + (CNT_W + 1)'(vld_p[i]);
      end
   end

   // Reads still in the BRAM pipe already own a FIFO slot, so the FIFO can never overflow.
   assign credit_sum = {1'b0, fifo_count} + inflight;
   assign issue      = (state == S_SCAN) && (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
   assign eol_issue  = (rx == width_q - 16'd1);
   assign last_issue = eol_issue && (ry == height_q - 16'd1);

   assign busy          = (state != S_IDLE);
   assign bus.bram_addr = addr_of(rx, ry);

   assign head_valid = (fifo_count != '0);
   assign fifo_wr    = vld_p[READ_LATENCY-1];
   assign fifo_rd    = head_valid && bus.pixel_ready;

   // Head fields are forced to zero while empty so the FIFO storage itself needs no reset.
   assign bus.pixel_valid = head_valid;
   assign bus.pixel_data  = head_valid ? fifo_data[rd_ptr] : '0;
   assign bus.pixel_x     = head_valid ? fifo_x[rd_ptr]    : '0;
   assign bus.pixel_y     = head_valid ? fifo_y[rd_ptr]    : '0;
   assign bus.pixel_eol   = head_valid && fifo_eol[rd_ptr];
   assign bus.pixel_last  = head_valid && fifo_last[rd_ptr];

   // Scan control: state, latched frame size and read cursor
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         done     <= 1'b0;
         width_q  <= '0;
         height_q <= '0;
         rx       <= '0;
         ry       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  width_q  <= width_clamp;
                  height_q <= height_clamp;
                  rx       <= '0;
                  ry       <= '0;
                  if ((width_clamp == '0) || (height_clamp == '0)) begin
                     done <= 1'b1;
                  end else begin
                     state <= S_SCAN;
                  end
               end
            end
            S_SCAN: begin
               if (issue) begin
                  if (last_issue) begin
                     state <= S_DRAIN;
                  end else if (eol_issue) begin
                     rx <= '0;
                     ry <= ry + 16'd1;
                  end else begin
                     rx <= rx + 16'd1;
                  end
               end
            end
            S_DRAIN: begin
               if (fifo_rd && bus.pixel_last) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Tag pipeline p0..pN: travels beside the BRAM read so data and coordinates arrive together
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= issue;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      tag_x_p[0]    <= rx;
      tag_y_p[0]    <= ry;
      tag_eol_p[0]  <= eol_issue;
      tag_last_p[0] <= last_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
         tag_x_p[i]    <= tag_x_p[i-1];
         tag_y_p[i]    <= tag_y_p[i-1];
         tag_eol_p[i]  <= tag_eol_p[i-1];
         tag_last_p[i] <= tag_last_p[i-1];
      end
   end

   // Skid FIFO: pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= ptr_next(wr_ptr);
         if (fifo_rd) rd_ptr <= ptr_next(rd_ptr);
         case ({fifo_wr, fifo_rd})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_data[wr_ptr] <= bus.bram_dout;
         fifo_x[wr_ptr]    <= tag_x_p[READ_LATENCY-1];
         fifo_y[wr_ptr]    <= tag_y_p[READ_LATENCY-1];
         fifo_eol[wr_ptr]  <= tag_eol_p[READ_LATENCY-1];
         fifo_last[wr_ptr] <= tag_last_p[READ_LATENCY-1];
      end
   end
endmodule

// File: tb/tb_framebuffer_reader.sv
// Directed bench for framebuffer_reader against a 2-cycle BRAM model holding data = addr[15:0].
module tb_framebuffer_reader;
   localparam int FW = 512;
   localparam int FH = 384;
   localparam int AB = 18;
   localparam int PW = 16;
   localparam int RL = 2;
   localparam int FD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] width_in;
   logic [15:0] height_in;
   logic        busy;
   logic        done;

   framebuffer_reader_if #(.ADDR_BITS(AB), .PIXEL_WIDTH(PW)) bus ();

   framebuffer_reader #(
      .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .ADDR_BITS(AB),
      .PIXEL_WIDTH(PW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .width_in(width_in),
      .height_in(height_in), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   logic [AB-1:0] mem_p0, mem_p1;
   always @(posedge clk) begin
      mem_p0 <= bus.bram_addr;
      mem_p1 <= mem_p0;
   end
   assign bus.bram_dout = mem_p1[15:0];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [49:0] pix_model(input int idx, input int w, input int h);
      int ws, x, y;
      logic [31:0] a;
      ws = (w < 1) ? 1 : w;
      x  = idx % ws;
      y  = idx / ws;
      a  = 32'(FW * y + x);
      return {a[15:0], x[15:0], y[15:0], (x == ws - 1), (idx == ws * h - 1)};
   endfunction

   task automatic run_frame(input string tag, input int w_in, input int h_in, input bit toggle_rdy,
                            input int restart_cyc, output int n_pix, output int first_vld,
                            output int done_cyc, output longint sum);
      int w, h, total, cyc, dones, budget, exp_final;
      logic [49:0] got, held;
      logic stall;
      w         = (w_in > FW) ? FW : w_in;
      h         = (h_in > FH) ? FH : h_in;
      total     = w * h;
      exp_final = (total > 0) ? FW * (h - 1) + (w - 1) : 0;
      budget    = toggle_rdy ? total * 3 + 50 : total + 50;
      n_pix = 0; first_vld = -1; done_cyc = -1; sum = 0; dones = 0; stall = 1'b0; held = '0;
      cyc = 0;
      start = 1'b1; width_in = 16'(w_in); height_in = 16'(h_in);
      while (cyc < budget && !(done_cyc >= 0 && cyc >= done_cyc + 4)) begin
         @(posedge clk); #1;
         cyc++;
         start    = (cyc == restart_cyc);
         width_in = (cyc == restart_cyc) ? 16'd2 : 16'(w_in);
         bus.pixel_ready = toggle_rdy ? (((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3)) : 1'b1;
         got = {bus.pixel_data, bus.pixel_x, bus.pixel_y, bus.pixel_eol, bus.pixel_last};
         if (cyc == 1) check({tag, "_busy1"}, busy, (total > 0));
         if (stall) check({tag, "_hold"}, {bus.pixel_valid, got}, {1'b1, held});
         if (bus.pixel_valid && first_vld < 0) first_vld = cyc;
         if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
            check({tag, "_busy_at_done"}, busy, 0);
            check({tag, "_final_addr"}, bus.bram_addr, exp_final);
         end
         if (bus.pixel_valid && bus.pixel_ready) begin
            check({tag, "_pix"}, got, pix_model(n_pix, w, h));
            sum += longint'(bus.pixel_data);
            n_pix++;
         end
         stall = bus.pixel_valid && !bus.pixel_ready;
         held  = got;
      end
      check({tag, "_done_count"}, dones, 1);
   endtask

   initial begin
      int np, fv, dc, hs, cyc;
      longint sm;
      rst = 1'b1; start = 1'b0; width_in = '0; height_in = '0; bus.pixel_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", {busy, done, bus.pixel_valid, bus.pixel_eol, bus.pixel_last}, 0);
      check("rst_addr", bus.bram_addr, 0);
      check("rst_data", {bus.pixel_data, bus.pixel_x, bus.pixel_y}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_frame("f4x2", 4, 2, 1'b0, 0, np, fv, dc, sm);
      check("f4x2_npix", np, 8);
      check("f4x2_first_valid", fv, 4);
      check("f4x2_done_cycle", dc, 12);
      check("f4x2_sum", sm, 2060);

      run_frame("bp4x2", 4, 2, 1'b1, 0, np, fv, dc, sm);
      check("bp4x2_npix", np, 8);
      check("bp4x2_sum", sm, 2060);

      run_frame("zero", 0, 5, 1'b0, 0, np, fv, dc, sm);
      check("zero_npix", np, 0);
      check("zero_no_valid", fv, -1);
      check("zero_done_cycle", dc, 1);

      run_frame("clamp", 600, 2, 1'b0, 0, np, fv, dc, sm);
      check("clamp_npix", np, 1024);
      check("clamp_done_cycle", dc, 1028);

      run_frame("restart", 4, 2, 1'b0, 5, np, fv, dc, sm);
      check("restart_npix", np, 8);
      check("restart_done_cycle", dc, 12);

      hs = 0; cyc = 0;
      start = 1'b1; width_in = 16'd4; height_in = 16'd2;
      while (hs < 3 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         bus.pixel_ready = 1'b1;
         if (bus.pixel_valid) begin
            check("prerst_pix", {bus.pixel_data, bus.pixel_x, bus.pixel_y, bus.pixel_eol,
                                 bus.pixel_last}, pix_model(hs, 4, 2));
            hs++;
         end
      end
      check("prerst_hs", hs, 3);
      @(posedge clk); #1;
      bus.pixel_ready = 1'b0;
      check("prerst_valid", bus.pixel_valid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_ctl", {busy, done, bus.pixel_valid, bus.pixel_eol, bus.pixel_last}, 0);
      check("midrst_addr", bus.bram_addr, 0);
      check("midrst_data", {bus.pixel_data, bus.pixel_x, bus.pixel_y}, 0);

      run_frame("after_rst", 4, 2, 1'b0, 0, np, fv, dc, sm);
      check("after_rst_npix", np, 8);
      check("after_rst_first_valid", fv, 4);
      check("after_rst_done_cycle", dc, 12);

      run_frame("wide", 512, 136, 1'b0, 0, np, fv, dc, sm);
      check("wide_npix", np, 69632);
      check("wide_sum", sm, 64'd2155837440);
      check("wide_done_cycle", dc, 69636);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/framebuffer_reader.md
# framebuffer_reader

Single-clock raster-order reader for the pixel BRAM's sys_clk port. It is the read-side counterpart of the ray-tracer's pixel write path: after a render, it walks the active screen region and streams each stored pixel with its coordinates over a valid/ready interface for frame dump, checksum or compare logic. BRAM read latency is hidden by a credit-controlled skid FIFO, so downstream backpressure never drops or duplicates a pixel.

## Interface
Parameters:
- FRAME_WIDTH, 512, row pitch in pixels; address = FRAME_WIDTH*y + x
- FRAME_HEIGHT, 384, maximum rows
- ADDR_BITS, 18, BRAM address width
- PIXEL_WIDTH, 16, padded pixel width
- READ_LATENCY, 2, cycles from bram_addr to valid bram_dout
- FIFO_DEPTH, 4, skid FIFO entries; must be >= READ_LATENCY+2

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a frame scan; ignored while busy
- width_in  in  16  active columns, latched at start, clamped to FRAME_WIDTH
- height_in  in  16  active rows, latched at start, clamped to FRAME_HEIGHT
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the scan completes
- bram_addr  out  ADDR_BITS  read address to pixel BRAM
- bram_dout  in  PIXEL_WIDTH  read data from pixel BRAM
- pixel_valid  out  1  output pixel available
- pixel_ready  in  1  downstream accepts the pixel
- pixel_data  out  PIXEL_WIDTH  pixel value
- pixel_x  out  16  column of pixel_data
- pixel_y  out  16  row of pixel_data
- pixel_eol  out  1  pixel_x == width-1
- pixel_last  out  1  last pixel of the frame

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: on start, latch the clamped width/height and zero the read cursor (rx, ry). If either dimension is 0, pulse done the next cycle, stay IDLE and emit no pixels. Otherwise go to SCAN.
- SCAN: issue a read in any cycle where fifo_count + inflight < FIFO_DEPTH. bram_addr = FRAME_WIDTH*ry + rx, computed at full ADDR_BITS width. Push (rx, ry, eol, last) into a READ_LATENCY-deep tag shift register alongside the read. Advance rx; at rx == width-1, wrap rx to 0 and increment ry. When the read with rx == width-1 and ry == height-1 issues, go to DRAIN.
- Data return: the data/tag pair is written to the FIFO exactly READ_LATENCY cycles after issue. The credit rule guarantees the FIFO never overflows, so no write is refused.
- Output: the FIFO head drives pixel_*. A handshake occurs when pixel_valid && pixel_ready. A write and a pop in the same cycle leave the count unchanged.
- DRAIN: issue no reads. On the handshake of the pixel_last entry, return to IDLE and pulse done in the following cycle.
- A start while busy is ignored and does not restart the scan.
- rst in any state, including mid-scan: state goes to IDLE, the FIFO, tags, inflight count and cursors clear, and in-flight BRAM data is discarded.
- Output values while pixel_valid is low are don't-care, except pixel_valid itself.

## Timing
- Reset values: busy=0, done=0, pixel_valid=0, bram_addr=0, pixel_data=0, pixel_x=0, pixel_y=0, pixel_eol=0, pixel_last=0.
- Cycle 0: start sampled. Cycle 1: first address issued and busy=1. Cycle 1+READ_LATENCY: FIFO written. Cycle 2+READ_LATENCY: pixel_valid=1 (cycle 4 at the defaults).
- With pixel_ready held high, throughput is 1 pixel/cycle and a W×H frame takes W*H+READ_LATENCY+2 cycles from start to done.
- pixel_valid must not drop without a handshake, and pixel_* must stay stable while valid && !ready.
- busy deasserts in the same cycle that done pulses.

## Test plan
- Reset, then start with width=4, height=2, ready high: 8 pixels at addresses 0,1,2,3,512,513,514,515 in order; pixel_eol on x=3; pixel_last only on (3,1); first valid in cycle 4; done in cycle 12.
- Same 4×2 scan with pixel_ready toggling 1,0,0,1,…: every pixel delivered exactly once, in order, with data held stable while stalled; bram reads never exceed 4 outstanding (fifo_count + inflight).
- Full 512×384 scan against a BRAM model holding data = addr[15:0]: 196608 pixels, checksum matches, final address 196607, done once.
- width=0 (height=5): done the cycle after start, pixel_valid never asserts; width=600 is clamped to 512 columns.
- Assert rst after 3 pixels have handshaked, with ready low: all outputs return to reset values the next cycle; a fresh start then re-scans from (0,0) and no stale data appears.
- Pulse start again mid-scan: ignored; pixel count and ordering unchanged; a single done.
